vx_pipe_adder_tree: RTL and testbench
=====================================

# vx_pipe_adder_tree

Pipelined, handshaked reduction tree for the convolution unit. It sums N lanes of DATAW-bit operands, either signed or unsigned, with per-lane masking, and registers every tree level. An optional accumulation mode sums successive beats until a `last` marker. It sits between the conv multiplier array and the writeback path, and applies back-pressure through a valid/ready pair.

## Interface
- `N`, 4: lane count; must be ≥2 (not required to be a power of 2).
- `DATAW`, 8: lane operand width.
- `SIGNED`, 1: 1 = lanes are two's-complement and sign-extended; 0 = lanes are zero-extended.
- `ACCUM`, 0: 1 = accumulate beats until `last_in`; 0 = every beat emits a result.
- `ACC_BITS`, 8: extra accumulator headroom bits. Ignored when `ACCUM`=0.
- Derived values: LEVELS = $clog2(N); OUTW = DATAW+LEVELS; RESW = OUTW+ACC_BITS if `ACCUM`, else OUTW.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  input beat valid.
- `ready_in`  out  1  block can accept a beat this cycle.
- `data_in`  in  N*DATAW  flat lanes; lane i occupies bits [(i+1)*DATAW-1 : i*DATAW].
- `mask_in`  in  N  1 = lane participates; 0 = lane is treated as zero.
- `last_in`  in  1  final beat of an accumulation group (ignored when `ACCUM`=0).
- `valid_out`  out  1  `dout` is valid.
- `ready_out`  in  1  consumer accepts `dout`.
- `dout`  out  RESW  sum.
- `beats_out`  out  16  number of beats folded into `dout`. Saturates at 0xFFFF. Always 1 when `ACCUM`=0.

## Operation
- Beat acceptance: a beat is accepted when `valid_in` && `ready_in` at a rising edge.
- Stage 0 (capture): each lane is masked, then sign- or zero-extended to OUTW and registered with a valid bit and `last`.
- Tree levels: level k (k = 1..LEVELS) registers the pairwise sums of level k-1 at OUTW width.
  - Missing leaves (non-power-of-2 N) read as 0.
  - Adds are exact; OUTW cannot overflow.
- Output stage, `ACCUM`=0: `dout` ← tree root (extended to RESW); `valid_out` ← 1; `beats_out` ← 1.
- Output stage, `ACCUM`=1:
  - Beat with `last`=0: acc ← acc + root and beat count increments; `valid_out` stays 0.
  - Beat with `last`=1: `dout` ← acc + root; `beats_out` ← count+1; `valid_out` ← 1; acc and count clear in the same edge.
  - A single beat with `last`=1 and an empty acc emits root with `beats_out`=1.
- Accumulator arithmetic: RESW wide and wraps modulo 2^RESW; there is no saturation. Signed results are two's-complement.
- Stall: stall = `valid_out` && !`ready_out`.
  - While stall is high, every pipeline register, valid bit, acc and count holds.
  - `ready_in` = !stall, combinational.
  - No beat is lost or duplicated.
- Empty pipeline slots are bubbles. Bubbles advance when not stalled and are never compressed.
- Output handshake: `valid_out` falls on the edge where `valid_out` && `ready_out`, unless a new result lands in the same edge.
- `dout` and `beats_out` are undefined-but-stable while `valid_out`=0. The implementation holds their last value.

## Timing
- Reset values (asynchronous, immediate): `valid_out`=0, `dout`=0, `beats_out`=0, all stage valid bits=0, acc=0, count=0.
  - `ready_in`=1 immediately after reset.
- Latency, `ACCUM`=0, no stall: a beat accepted in cycle c gives `valid_out`=1 in cycle c+LEVELS+2.
  - N=4: c+4. N=8: c+5.
- Latency, `ACCUM`=1: the result appears LEVELS+2 cycles after the `last` beat is accepted.
- Throughput: one beat per cycle when `ready_out` is held high.
- Stall cost: each stalled cycle adds exactly one cycle to every in-flight beat.
- Reset mid-operation: all in-flight beats and any partial accumulation are discarded. Nothing emits after reset deasserts until new beats arrive.
- Simultaneous output consume and new result: `valid_out` stays 1, and `dout` updates to the new value at that edge.

## Test plan
- `N`=4, `DATAW`=8, `SIGNED`=1. Beat {1,2,3,4} with mask 4'hF accepted in cycle 10 → `valid_out`=1 in cycle 14, `dout`=10, `beats_out`=1.
- Signed extremes: {-128,-128,-128,-128} → `dout`=10'h200 (-512). With `SIGNED`=0 and {255,255,255,255} → `dout`=1020.
- Mask and non-power-of-2: `N`=5, mask 5'b10101, {10,20,30,40,50} → `dout`=90. Latency is 5 cycles.
- Accumulate: `ACCUM`=1. Beats 10,20,30 summed per beat, `last` only on the third → exactly one `valid_out` with `dout`=60, `beats_out`=3. The next group starts from 0.
- Back-pressure: 8 back-to-back beats with `ready_out` low for cycles 3-6 → `ready_in` low while stalled. `dout` is held stable. All 8 results emerge in order, with no loss or duplication.
- Reset mid-flight: assert `reset` with 3 beats in the pipe and a partial accumulation → all outputs are 0 within the same cycle. No stale result emits afterwards, and the next group sums from zero.

Source files
------------

// File: rtl/vx_pipe_adder_tree.sv
// vx_pipe_adder_tree
// Pipelined, handshaked reduction tree for the convolution unit. Each beat
// carries N lanes of DATAW bits. The block masks the lanes, extends them
// (signed or unsigned) and sums them through LEVELS registered adder levels.
// In ACCUM mode it folds successive tree sums into an accumulator until a
// beat marked with last arrives.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   valid_in   input beat valid
//   ready_in   block accepts a beat this cycle (combinational, = !stall)
//   data_in    N*DATAW flat lanes, lane i at [(i+1)*DATAW-1 : i*DATAW]
//   mask_in    per-lane enable, 0 = lane reads as zero
//   last_in    closes an accumulation group (ACCUM=1 only)
//   valid_out  dout/beats_out valid
//   ready_out  consumer accepts dout
//   dout       RESW-bit sum
//   beats_out  number of beats folded into dout, saturating at 0xFFFF
module vx_pipe_adder_tree #(
  parameter int N        = 4,
  parameter int DATAW    = 8,
  parameter int SIGNED   = 1,
  parameter int ACCUM    = 0,
  parameter int ACC_BITS = 8,
  localparam int LEVELS  = $clog2(N),
  localparam int OUTW    = DATAW + LEVELS,
  localparam int RESW    = (ACCUM != 0) ? OUTW + ACC_BITS : OUTW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [N*DATAW-1:0]   data_in,
  input  logic [N-1:0]         mask_in,
  input  logic                 last_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [RESW-1:0]      dout,
  output logic [15:0]          beats_out
);

  // The tree is stored heap-style: node j has children 2j and 2j+1, leaves
  // sit at NP..2*NP-1 and the root is node 1. Each node is one register, so
  // every tree level is a pipeline stage. Leaves beyond N are held at zero.
  localparam int NP = 1 << LEVELS;

  logic [OUTW-1:0]  leaf   [NP];
  logic [OUTW-1:0]  node_q [1:2*NP-1];
  logic [LEVELS:0]  vld_q;
  logic [LEVELS:0]  last_q;
  logic [RESW-1:0]  acc_q;
  logic [RESW-1:0]  root_ext;
  logic [RESW-1:0]  acc_sum;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_inc;
  logic             stall;

  assign stall    = valid_out && !ready_out;
  assign ready_in = !stall;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      leaf[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      logic [DATAW-1:0] lane;
      lane = data_in[i*DATAW +: DATAW] & {DATAW{mask_in[i]}};
      if (SIGNED != 0) begin
        leaf[i] = OUTW'($signed(lane));
      end else begin
        leaf[i] = OUTW'(lane);
      end
    end
  end

  always_comb begin
    if (SIGNED != 0) begin
      root_ext = RESW'($signed(node_q[1]));
    end else begin
      root_ext = RESW'(node_q[1]);
    end
  end

  assign acc_sum = acc_q + root_ext;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 1; j < 2*NP; j++) begin
        node_q[j] <= '0;
      end
      vld_q     <= '0;
      last_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_out <= 1'b0;
      dout      <= '0;
      beats_out <= '0;
    end else if (!stall) begin
      // Data registers advance with bubbles too; only the valid bits matter.
      for (int i = 0; i < NP; i++) begin
        node_q[NP+i] <= leaf[i];
      end
      for (int j = 1; j < NP; j++) begin
        node_q[j] <= node_q[2*j] + node_q[2*j+1];
      end
      vld_q  <= {vld_q[LEVELS-1:0], valid_in};
      last_q <= {last_q[LEVELS-1:0], last_in};

      if (vld_q[LEVELS]) begin
        if (ACCUM == 0) begin
          dout      <= root_ext;
          beats_out <= 16'd1;
          valid_out <= 1'b1;
        end else if (last_q[LEVELS]) begin
          dout      <= acc_sum;
          beats_out <= cnt_inc;
          valid_out <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q     <= acc_sum;
          cnt_q     <= cnt_inc;
          valid_out <= 1'b0;
        end
      end else begin
        // Not stalled means the held result was consumed (or none was held).
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vx_pipe_adder_tree.sv
module tb_vx_pipe_adder_tree;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: N=4, signed, no accumulation (RESW=10)
  logic        a_valid, a_rin, a_last, a_vout, a_rout;
  logic [31:0] a_data;
  logic [3:0]  a_mask;
  logic [9:0]  a_dout;
  logic [15:0] a_beats;

  // Instance B: N=5, unsigned, accumulating (OUTW=11, RESW=19)
  logic        b_valid, b_rin, b_last, b_vout, b_rout;
  logic [39:0] b_data;
  logic [4:0]  b_mask;
  logic [18:0] b_dout;
  logic [15:0] b_beats;

  vx_pipe_adder_tree #(.N(4), .DATAW(8), .SIGNED(1), .ACCUM(0), .ACC_BITS(8)) dut_a (
    .clk(clk), .reset(reset), .valid_in(a_valid), .ready_in(a_rin),
    .data_in(a_data), .mask_in(a_mask), .last_in(a_last),
    .valid_out(a_vout), .ready_out(a_rout), .dout(a_dout), .beats_out(a_beats));

  vx_pipe_adder_tree #(.N(5), .DATAW(8), .SIGNED(0), .ACCUM(1), .ACC_BITS(8)) dut_b (
    .clk(clk), .reset(reset), .valid_in(b_valid), .ready_in(b_rin),
    .data_in(b_data), .mask_in(b_mask), .last_in(b_last),
    .valid_out(b_vout), .ready_out(b_rout), .dout(b_dout), .beats_out(b_beats));

  typedef struct packed {
    logic [18:0] d;
    logic [15:0] b;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  int     errors = 0;
  int     checks = 0;
  longint acc_b  = 0;
  int     cnt_b  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: plain integer sum of the enabled lanes.
  function automatic logic [9:0] model_a(input logic [31:0] d, input logic [3:0] m);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) s += int'($signed(d[i*8 +: 8]));
    return s[9:0];
  endfunction

  function automatic int model_b(input logic [39:0] d, input logic [4:0] m);
    int s;
    s = 0;
    for (int i = 0; i < 5; i++)
      if (m[i]) s += int'(d[i*8 +: 8]);
    return s;
  endfunction

  // Drivers: called at posedge+1, return at posedge+1 after the accepting edge.
  task automatic send_a(input logic [31:0] d, input logic [3:0] m);
    bit ok;
    int tries;
    exp_t e;
    a_valid = 1'b1; a_data = d; a_mask = m;
    ok = 1'b0; tries = 0;
    while (!ok && tries < 1000) begin
      @(negedge clk); ok = a_rin;
      @(posedge clk); #1;
      tries++;
    end
    a_valid = 1'b0;
    if (!ok) flag("a_accept_timeout");
    else begin
      e.d = 19'(model_a(d, m));
      e.b = 16'd1;
      qa.push_back(e);
    end
  endtask

  task automatic send_b(input logic [39:0] d, input logic [4:0] m, input logic last);
    bit ok;
    int tries;
    exp_t e;
    b_valid = 1'b1; b_data = d; b_mask = m; b_last = last;
    ok = 1'b0; tries = 0;
    while (!ok && tries < 1000) begin
      @(negedge clk); ok = b_rin;
      @(posedge clk); #1;
      tries++;
    end
    b_valid = 1'b0; b_last = 1'b0;
    if (!ok) flag("b_accept_timeout");
    else begin
      acc_b += longint'(model_b(d, m));
      cnt_b++;
      if (last) begin
        e.d = acc_b[18:0];
        e.b = (cnt_b > 65535) ? 16'hFFFF : 16'(cnt_b);
        qb.push_back(e);
        acc_b = 0;
        cnt_b = 0;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin step(1); n++; end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    step(3);
  endtask

  // Cycles from acceptance edge to valid_out (send returns with count 1).
  task automatic latency(input bit use_b, input int exp_lat, input string name);
    int n;
    n = 1;
    while (!(use_b ? b_vout : a_vout) && n < 30) begin step(1); n++; end
    check(name, n, exp_lat);
  endtask

  // Scoreboard monitors: compare every presented result with the queue head,
  // pop on handshake. While stalled, the head must stay on dout.
  always @(negedge clk) begin
    if (!reset && a_vout) begin
      if (qa.size() == 0) flag("a_unexpected_output");
      else begin
        check("a_dout", a_dout, qa[0].d[9:0]);
        check("a_beats", a_beats, qa[0].b);
        if (!a_rout) check("a_ready_in_stall", a_rin, 0);
        else void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_vout) begin
      if (qb.size() == 0) flag("b_unexpected_output");
      else begin
        check("b_dout", b_dout, qb[0].d);
        check("b_beats", b_beats, qb[0].b);
        if (!b_rout) check("b_ready_in_stall", b_rin, 0);
        else void'(qb.pop_front());
      end
    end
  end

  initial begin
    bit done;
    reset = 1'b1;
    a_valid = 0; a_data = 0; a_mask = 0; a_last = 0; a_rout = 1;
    b_valid = 0; b_data = 0; b_mask = 0; b_last = 0; b_rout = 1;
    #1;
    check("rst_a_vout", a_vout, 0);
    check("rst_a_dout", a_dout, 0);
    check("rst_a_beats", a_beats, 0);
    check("rst_b_vout", b_vout, 0);
    check("rst_b_dout", b_dout, 0);
    check("rst_b_beats", b_beats, 0);
    step(3);
    reset = 1'b0;
    step(1);
    check("rst_a_ready_in", a_rin, 1);
    check("rst_b_ready_in", b_rin, 1);

    // A: basic sum and latency LEVELS+2 = 4
    send_a(32'h04030201, 4'hF);
    latency(1'b0, 4, "a_latency");
    wait_idle();
    // A: signed extremes, -512
    send_a(32'h80808080, 4'hF);
    send_a(32'h7F7F7F7F, 4'hF);
    send_a(32'h7F80FF01, 4'b1010);
    wait_idle();

    // A: back-pressure during 8 back-to-back beats
    fork
      begin
        for (int i = 0; i < 8; i++) send_a($urandom, 4'hF);
      end
      begin
        for (int k = 0; k < 14; k++) begin
          a_rout = !(k >= 5 && k <= 8);
          step(1);
        end
        a_rout = 1'b1;
      end
    join
    wait_idle();

    // A: random beats, random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          step($urandom_range(0, 2));
          send_a($urandom, 4'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          a_rout = ($urandom % 4) != 0;
          step(1);
        end
        a_rout = 1'b1;
      end
    join
    wait_idle();

    // B: mask, non-power-of-2, latency LEVELS+2 = 5
    send_b(40'h32281E140A, 5'b10101, 1'b1);
    latency(1'b1, 5, "b_latency");
    wait_idle();
    send_b(40'h00FFFFFFFF, 5'b01111, 1'b1);
    // B: accumulate 10+20+30, then a fresh group
    send_b(40'h000000000A, 5'b00001, 1'b0);
    send_b(40'h0000000014, 5'b00001, 1'b0);
    send_b(40'h000000001E, 5'b00001, 1'b1);
    send_b(40'h0000000005, 5'b00001, 1'b1);
    wait_idle();
    // B: long group that wraps the 19-bit accumulator
    for (int i = 0; i < 420; i++) send_b(40'hFFFFFFFFFF, 5'h1F, i == 419);
    wait_idle();

    // B: random groups, random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          step($urandom_range(0, 1));
          send_b(40'({$urandom, $urandom}), 5'($urandom), (i == 49) || ($urandom % 3 == 0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          b_rout = ($urandom % 3) != 0;
          step(1);
        end
        b_rout = 1'b1;
      end
    join
    wait_idle();

    // Reset with beats in flight and a partial accumulation
    fork
      begin
        for (int i = 0; i < 3; i++) send_a($urandom, 4'hF);
      end
      begin
        send_b(40'h0000000063, 5'b00001, 1'b0);
        send_b(40'h0000000063, 5'b00001, 1'b0);
      end
    join
    reset = 1'b1;
    qa.delete(); qb.delete();
    acc_b = 0; cnt_b = 0;
    #1;
    check("mid_rst_a_vout", a_vout, 0);
    check("mid_rst_a_dout", a_dout, 0);
    check("mid_rst_a_beats", a_beats, 0);
    check("mid_rst_b_vout", b_vout, 0);
    check("mid_rst_b_dout", b_dout, 0);
    check("mid_rst_b_beats", b_beats, 0);
    step(2);
    reset = 1'b0;
    step(15);
    send_b(40'h0000000007, 5'b00001, 1'b1);
    send_a(32'h01010101, 4'hF);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
